// File: rtl/lsu_sram_pkg.sv
// Shared types, default parameters and width helpers for the LSU-to-SRAM bridge.
package lsu_sram_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam int DEF_CPU_DW      = 32;
  localparam int DEF_SRAM_DW     = 16;
  localparam int DEF_ADDR_W      = 18;
  localparam int DEF_WAIT_CYCLES = 0;

  function automatic int clog2_f(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

  function automatic int beats_f(input int cpu_dw, input int sram_dw);
    return cpu_dw / sram_dw;
  endfunction

  // Beat index register is kept at least one bit wide even for a single beat.
  function automatic int idx_w_f(input int beats);
    return (beats > 1) ? clog2_f(beats) : 1;
  endfunction

endpackage

// File: rtl/lsu_sram_wait_timer.sv
// Per-beat wait-state timer: reloaded at the start of every beat, beat_done
// marks the last cycle of the beat.
module sram_wait_timer #(
  parameter int WAIT_CYCLES = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic beat_done
);

  generate
    if (WAIT_CYCLES == 0) begin : g_none
      logic unused_in;
      assign unused_in = ^{clk, reset, load};
      assign beat_done = 1'b1;
    end else begin : g_cnt
      localparam int CW = $clog2(WAIT_CYCLES + 1);
      logic [CW-1:0] cnt;

      always_ff @(posedge clk) begin
        if (!reset) begin
          cnt <= '0;
        end else if (load) begin
          cnt <= CW'(WAIT_CYCLES);
        end else if (cnt != '0) begin
          cnt <= cnt - 1'b1;
        end
      end

      assign beat_done = (cnt == '0);
    end
  endgenerate

endmodule

// File: rtl/lsu_sram_bridge.sv
// Bridge from the core load/store port to an async SRAM: one CPU word is split
// into SRAM_DW beats, each held for WAIT_CYCLES+1 cycles.
//
// state  | meaning
// IDLE   | req_ready high, waiting for a request
// ACCESS | driving one SRAM beat, WAIT_CYCLES+1 cycles per beat
// RESP   | one-cycle rsp_valid pulse, SRAM controls inactive
module lsu_sram_bridge
  import lsu_sram_pkg::*;
#(
  parameter int CPU_DW      = DEF_CPU_DW,
  parameter int SRAM_DW     = DEF_SRAM_DW,
  parameter int ADDR_W      = DEF_ADDR_W,
  parameter int WAIT_CYCLES = DEF_WAIT_CYCLES
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [31:0]            req_addr,
  input  logic [CPU_DW-1:0]      req_wdata,
  input  logic [CPU_DW/8-1:0]    req_be,
  output logic                   rsp_valid,
  output logic [CPU_DW-1:0]      rsp_rdata,
  output logic [ADDR_W-1:0]      SRAM_ADDR,
  output logic [SRAM_DW-1:0]     SRAM_D,
  input  logic [SRAM_DW-1:0]     SRAM_Q,
  output logic                   SRAM_CE_N,
  output logic                   SRAM_WE_N,
  output logic                   SRAM_OE_N,
  output logic [SRAM_DW/8-1:0]   SRAM_BE_N
);

  localparam int BEATS = beats_f(CPU_DW, SRAM_DW);
  localparam int BL    = clog2_f(BEATS);
  localparam int BW    = idx_w_f(BEATS);
  localparam int SB    = clog2_f(SRAM_DW / 8);
  localparam int LB    = SRAM_DW / 8;
  localparam int CB    = CPU_DW / 8;

  localparam logic [1:0] S_IDLE   = IDLE;
  localparam logic [1:0] S_ACCESS = ACCESS;
  localparam logic [1:0] S_RESP   = RESP;

  logic [1:0]         state, state_n;
  logic [BW-1:0]      beat, beat_n;
  logic               we_r;
  logic [ADDR_W-1:0]  addr_r;
  logic [CPU_DW-1:0]  wdata_r, rdata;
  logic [CB-1:0]      be_r;
  logic               beat_done, drive, stop, found;
  logic [BW-1:0]      idx;
  logic               src_we;
  logic [ADDR_W-1:0]  src_addr, out_addr, sram_addr_r;
  logic [CPU_DW-1:0]  src_wdata;
  logic [CB-1:0]      src_be;
  logic [SRAM_DW-1:0] out_d, sram_d_r;
  logic [LB-1:0]      out_be_n, sram_be_n_r;
  logic               ce_n_r, we_n_r, oe_n_r;
  logic               unused_addr;

  assign unused_addr = ^req_addr;

  // Lowest beat at or above 'from' with any byte enabled; MSB of result = found.
  function automatic logic [BW:0] next_en(input logic [CB-1:0] be_v, input int from);
    logic          f;
    logic [BW-1:0] b_idx;
    f     = 1'b0;
    b_idx = '0;
    for (int b = BEATS - 1; b >= 0; b--) begin
      if (b >= from && (|be_v[b*LB +: LB])) begin
        f     = 1'b1;
        b_idx = BW'(b);
      end
    end
    return {f, b_idx};
  endfunction

  sram_wait_timer #(.WAIT_CYCLES(WAIT_CYCLES)) u_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (drive),
    .beat_done (beat_done)
  );

  always_comb begin
    state_n   = state;
    beat_n    = beat;
    drive     = 1'b0;
    stop      = 1'b0;
    found     = 1'b0;
    idx       = '0;
    src_we    = we_r;
    src_addr  = addr_r;
    src_wdata = wdata_r;
    src_be    = be_r;

    case (state)
      S_IDLE: begin
        if (req_valid) begin
          src_we    = req_we;
          src_addr  = req_addr[ADDR_W-1+SB -: ADDR_W];
          src_wdata = req_wdata;
          src_be    = req_be;
          {found, idx} = req_we ? next_en(req_be, 0) : {1'b1, {BW{1'b0}}};
          if (found) begin
            state_n = S_ACCESS;
            beat_n  = idx;
            drive   = 1'b1;
          end else begin
            state_n = S_RESP;
          end
        end
      end
      S_ACCESS: begin
        if (beat_done) begin
          if (!we_r) begin
            found = (int'(beat) < BEATS - 1);
            idx   = beat + 1'b1;
          end else begin
            {found, idx} = next_en(be_r, int'(beat) + 1);
          end
          if (found) begin
            beat_n = idx;
            drive  = 1'b1;
          end else begin
            state_n = S_RESP;
            stop    = 1'b1;
          end
        end
      end
      S_RESP:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase

    // Low address bits select the beat within the CPU word.
    out_addr = src_addr;
    for (int i = 0; i < BL; i++) out_addr[i] = beat_n[i];
    out_d    = src_wdata[int'(beat_n)*SRAM_DW +: SRAM_DW];
    out_be_n = src_we ? ~src_be[int'(beat_n)*LB +: LB] : '0;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state       <= S_IDLE;
      beat        <= '0;
      we_r        <= 1'b0;
      addr_r      <= '0;
      wdata_r     <= '0;
      be_r        <= '0;
      rdata       <= '0;
      sram_addr_r <= '0;
      sram_d_r    <= '0;
      ce_n_r      <= 1'b1;
      we_n_r      <= 1'b1;
      oe_n_r      <= 1'b1;
      sram_be_n_r <= '1;
    end else begin
      state <= state_n;
      beat  <= beat_n;
      if (state == S_IDLE && req_valid) begin
        we_r    <= req_we;
        addr_r  <= req_addr[ADDR_W-1+SB -: ADDR_W];
        wdata_r <= req_wdata;
        be_r    <= req_be;
      end
      if (state == S_ACCESS && beat_done && !we_r) begin
        rdata[int'(beat)*SRAM_DW +: SRAM_DW] <= SRAM_Q;
      end
      if (drive) begin
        sram_addr_r <= out_addr;
        ce_n_r      <= 1'b0;
        we_n_r      <= !src_we;
        oe_n_r      <= src_we;
        sram_be_n_r <= out_be_n;
        if (src_we) sram_d_r <= out_d;
      end else if (stop) begin
        ce_n_r      <= 1'b1;
        we_n_r      <= 1'b1;
        oe_n_r      <= 1'b1;
        sram_be_n_r <= '1;
      end
    end
  end

  assign req_ready = (state == S_IDLE);
  assign rsp_valid = (state == S_RESP);
  assign rsp_rdata = rdata;
  assign SRAM_ADDR = sram_addr_r;
  assign SRAM_D    = sram_d_r;
  assign SRAM_CE_N = ce_n_r;
  assign SRAM_WE_N = we_n_r;
  assign SRAM_OE_N = oe_n_r;
  assign SRAM_BE_N = sram_be_n_r;

endmodule

// File: tb/tb_lsu_sram_bridge.sv
// Directed bench for lsu_sram_bridge: vector table at default parameters, plus
// wait-state, mid-access reset and back-to-back sequences.
module tb_lsu_sram_bridge;

  logic        clk, reset;
  logic        req_valid, req_ready, req_we, rsp_valid;
  logic [31:0] req_addr, req_wdata, rsp_rdata;
  logic [3:0]  req_be;
  logic [17:0] sram_addr;
  logic [15:0] sram_d, sram_q;
  logic        ce_n, we_n, oe_n;
  logic [1:0]  be_n;

  logic        r2_valid, r2_ready, r2_we, r2_rsp;
  logic [31:0] r2_addr, r2_wdata, r2_rdata;
  logic [3:0]  r2_be;
  logic [17:0] sram_addr2;
  logic [15:0] sram_d2, sram_q2;
  logic        ce_n2, we_n2, oe_n2;
  logic [1:0]  be_n2;

  logic [15:0] mem  [64];
  logic [15:0] mem2 [64];
  logic        ld_en;
  logic [5:0]  ld_addr;
  logic [15:0] ld_data;

  int n_checks = 0;
  int n_err    = 0;

  lsu_sram_bridge dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .SRAM_ADDR(sram_addr),
    .SRAM_D(sram_d), .SRAM_Q(sram_q), .SRAM_CE_N(ce_n), .SRAM_WE_N(we_n),
    .SRAM_OE_N(oe_n), .SRAM_BE_N(be_n)
  );

  lsu_sram_bridge #(.WAIT_CYCLES(2)) dut_w2 (
    .clk(clk), .reset(reset), .req_valid(r2_valid), .req_ready(r2_ready),
    .req_we(r2_we), .req_addr(r2_addr), .req_wdata(r2_wdata), .req_be(r2_be),
    .rsp_valid(r2_rsp), .rsp_rdata(r2_rdata), .SRAM_ADDR(sram_addr2),
    .SRAM_D(sram_d2), .SRAM_Q(sram_q2), .SRAM_CE_N(ce_n2), .SRAM_WE_N(we_n2),
    .SRAM_OE_N(oe_n2), .SRAM_BE_N(be_n2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM models: 64 words, aliased on the low address bits.
  assign sram_q  = mem[sram_addr[5:0]];
  assign sram_q2 = mem2[sram_addr2[5:0]];

  always @(posedge clk) begin
    if (ld_en) begin
      mem[ld_addr] <= ld_data;
    end else if (!ce_n && !we_n) begin
      if (!be_n[0]) mem[sram_addr[5:0]][7:0]  <= sram_d[7:0];
      if (!be_n[1]) mem[sram_addr[5:0]][15:8] <= sram_d[15:8];
    end
  end

  always @(posedge clk) begin
    if (ld_en) mem2[ld_addr] <= ld_data;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          lat;
    int          nb;
    logic [17:0] a0;
    logic [15:0] d0;
    logic [1:0]  bn0;
    logic [17:0] a1;
    logic [15:0] d1;
    logic [1:0]  bn1;
    logic [31:0] rdata;
  } vec_t;

  vec_t vecs [13];

  int          t_lat, t_nb, t_ctl_bad;
  logic [17:0] t_a  [4];
  logic [15:0] t_d  [4];
  logic [1:0]  t_bn [4];
  logic [31:0] t_rd;
  logic [2:0]  t_after;

  task automatic run_req(input logic we, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [3:0] be);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd; req_be = be;
    @(posedge clk); #1;
    req_valid = 1'b0;
    t_lat = -1; t_nb = 0; t_ctl_bad = 0; t_rd = '0;
    for (int k = 0; k < 4; k++) begin
      t_a[k] = '0; t_d[k] = '0; t_bn[k] = '0;
    end
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (!ce_n) begin
        if (t_nb < 4) begin
          t_a[t_nb] = sram_addr; t_d[t_nb] = sram_d; t_bn[t_nb] = be_n;
        end
        if (we_n !== !we || oe_n !== we) t_ctl_bad++;
        t_nb++;
      end
      if (rsp_valid) begin
        t_lat = c;
        t_rd  = rsp_rdata;
        break;
      end
    end
    @(negedge clk);
    t_after = {rsp_valid, req_ready, ce_n};
  endtask

  logic [17:0] w2_exp [6];
  logic [17:0] w2_a   [8];
  int          w2_n, w2_lat, w2_bad;
  logic [31:0] w2_rd;
  int          rsp_seen, acc_cnt, rsp_cnt;
  int          acc_c [4];
  int          rsp_c [4];
  logic [31:0] rsp_d [4];
  logic        acc_now;

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_be = '0;
    r2_valid = 1'b0; r2_we = 1'b0; r2_addr = '0; r2_wdata = '0; r2_be = '0;
    ld_en = 1'b1; ld_addr = '0; ld_data = '0;

    vecs[0]  = '{1'b0, 32'h10,       32'h0,        4'h0, 3, 2, 18'h8,     16'h0,    2'b00, 18'h9,     16'h0,    2'b00, 32'hDEADBEEF};
    vecs[1]  = '{1'b1, 32'h20,       32'h12345678, 4'hF, 3, 2, 18'h10,    16'h5678, 2'b00, 18'h11,    16'h1234, 2'b00, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 32'h20,       32'h12345678, 4'hC, 2, 1, 18'h11,    16'h1234, 2'b00, 18'h0,     16'h0,    2'b00, 32'hDEADBEEF};
    vecs[3]  = '{1'b1, 32'h20,       32'h00009900, 4'h2, 2, 1, 18'h10,    16'h9900, 2'b01, 18'h0,     16'h0,    2'b00, 32'hDEADBEEF};
    vecs[4]  = '{1'b1, 32'h20,       32'hFFFFFFFF, 4'h0, 1, 0, 18'h0,     16'h0,    2'b00, 18'h0,     16'h0,    2'b00, 32'hDEADBEEF};
    vecs[5]  = '{1'b0, 32'h20,       32'h0,        4'h0, 3, 2, 18'h10,    16'h0,    2'b00, 18'h11,    16'h0,    2'b00, 32'h12349978};
    vecs[6]  = '{1'b0, 32'h13,       32'h0,        4'h0, 3, 2, 18'h8,     16'h0,    2'b00, 18'h9,     16'h0,    2'b00, 32'hDEADBEEF};
    vecs[7]  = '{1'b1, 32'h0,        32'hCAFEF00D, 4'h8, 2, 1, 18'h1,     16'hCAFE, 2'b01, 18'h0,     16'h0,    2'b00, 32'hDEADBEEF};
    vecs[8]  = '{1'b1, 32'h4,        32'h11112222, 4'h1, 2, 1, 18'h2,     16'h2222, 2'b10, 18'h0,     16'h0,    2'b00, 32'hDEADBEEF};
    vecs[9]  = '{1'b0, 32'h0,        32'h0,        4'h0, 3, 2, 18'h0,     16'h0,    2'b00, 18'h1,     16'h0,    2'b00, 32'hCA000000};
    vecs[10] = '{1'b0, 32'hFFFFFFFC, 32'h0,        4'h0, 3, 2, 18'h3FFFE, 16'h0,    2'b00, 18'h3FFFF, 16'h0,    2'b00, 32'h45670123};
    vecs[11] = '{1'b1, 32'h8,        32'hAABBCCDD, 4'h4, 2, 1, 18'h5,     16'hAABB, 2'b10, 18'h0,     16'h0,    2'b00, 32'h45670123};
    vecs[12] = '{1'b0, 32'h8,        32'h0,        4'h0, 3, 2, 18'h4,     16'h0,    2'b00, 18'h5,     16'h0,    2'b00, 32'h00BB0000};

    // Preload both SRAM models while the bridges are held in reset.
    for (int i = 0; i < 64; i++) begin
      ld_addr = 6'(i);
      ld_data = (i == 8) ? 16'hBEEF : (i == 9) ? 16'hDEAD :
                (i == 62) ? 16'h0123 : (i == 63) ? 16'h4567 : 16'h0000;
      @(posedge clk); #1;
    end
    ld_en = 1'b0;

    @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_rdata", rsp_rdata, 32'h0);
    check("rst_addr", 32'(sram_addr), 32'h0);
    check("rst_d", 32'(sram_d), 32'h0);
    check("rst_ctl", 32'({ce_n, we_n, oe_n}), 32'h7);
    check("rst_be_n", 32'(be_n), 32'h3);
    reset = 1'b1;

    for (int i = 0; i < 13; i++) begin
      run_req(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be);
      check($sformatf("v%0d_lat", i), 32'(t_lat), 32'(vecs[i].lat));
      check($sformatf("v%0d_beats", i), 32'(t_nb), 32'(vecs[i].nb));
      if (vecs[i].nb >= 1) begin
        check($sformatf("v%0d_addr0", i), 32'(t_a[0]), 32'(vecs[i].a0));
        check($sformatf("v%0d_be_n0", i), 32'(t_bn[0]), 32'(vecs[i].bn0));
        if (vecs[i].we) check($sformatf("v%0d_d0", i), 32'(t_d[0]), 32'(vecs[i].d0));
      end
      if (vecs[i].nb >= 2) begin
        check($sformatf("v%0d_addr1", i), 32'(t_a[1]), 32'(vecs[i].a1));
        check($sformatf("v%0d_be_n1", i), 32'(t_bn[1]), 32'(vecs[i].bn1));
        if (vecs[i].we) check($sformatf("v%0d_d1", i), 32'(t_d[1]), 32'(vecs[i].d1));
      end
      check($sformatf("v%0d_rdata", i), t_rd, vecs[i].rdata);
      check($sformatf("v%0d_ctl", i), 32'(t_ctl_bad), 32'd0);
      check($sformatf("v%0d_after", i), 32'(t_after), 32'b011);
    end

    // Wait states: each beat held three cycles.
    w2_exp[0] = 18'h8; w2_exp[1] = 18'h8; w2_exp[2] = 18'h8;
    w2_exp[3] = 18'h9; w2_exp[4] = 18'h9; w2_exp[5] = 18'h9;
    @(negedge clk);
    r2_valid = 1'b1; r2_addr = 32'h10;
    @(posedge clk); #1;
    r2_valid = 1'b0;
    w2_n = 0; w2_lat = -1; w2_bad = 0; w2_rd = '0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (!ce_n2) begin
        if (w2_n < 8) w2_a[w2_n] = sram_addr2;
        if (oe_n2 !== 1'b0 || we_n2 !== 1'b1 || be_n2 !== 2'b00) w2_bad++;
        w2_n++;
      end
      if (r2_rsp) begin
        w2_lat = c; w2_rd = r2_rdata;
        break;
      end
    end
    check("w2_active_cycles", 32'(w2_n), 32'd6);
    for (int k = 0; k < 6; k++) begin
      if (k < w2_n) check($sformatf("w2_addr%0d", k), 32'(w2_a[k]), 32'(w2_exp[k]));
    end
    check("w2_lat", 32'(w2_lat), 32'd7);
    check("w2_rdata", w2_rd, 32'hDEADBEEF);
    check("w2_ctl", 32'(w2_bad), 32'd0);
    check("w2_d", 32'(sram_d2), 32'h0);

    // Reset during beat 1 of a full write.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678; req_be = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("mr_beat0_ce", 32'(ce_n), 32'd0);
    @(negedge clk);
    check("mr_beat1_addr", 32'(sram_addr), 32'h11);
    reset = 1'b0;
    @(negedge clk);
    check("mr_ctl", 32'({ce_n, we_n, oe_n}), 32'h7);
    check("mr_be_n", 32'(be_n), 32'h3);
    check("mr_ready", 32'(req_ready), 32'd1);
    check("mr_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mr_addr", 32'(sram_addr), 32'h0);
    check("mr_d", 32'(sram_d), 32'h0);
    check("mr_rdata", rsp_rdata, 32'h0);
    reset = 1'b1;
    rsp_seen = 0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      if (rsp_valid) rsp_seen++;
    end
    check("mr_no_rsp", 32'(rsp_seen), 32'd0);

    // Request held through a busy period, then back-to-back reads.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10;
    acc_cnt = 0; rsp_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      acc_now = req_valid && req_ready;
      if (rsp_valid) begin
        if (rsp_cnt < 4) begin rsp_c[rsp_cnt] = c; rsp_d[rsp_cnt] = rsp_rdata; end
        rsp_cnt++;
      end
      if (acc_now) begin
        if (acc_cnt < 4) acc_c[acc_cnt] = c;
        acc_cnt++;
      end
      @(posedge clk); #1;
      if (acc_now) begin
        if (acc_cnt == 1) req_addr = 32'h0;
        else req_valid = 1'b0;
      end
      @(negedge clk);
    end
    check("b2b_accepts", 32'(acc_cnt), 32'd2);
    check("b2b_responses", 32'(rsp_cnt), 32'd2);
    if (acc_cnt >= 2) begin
      check("b2b_acc0_cycle", 32'(acc_c[0]), 32'd0);
      check("b2b_acc1_cycle", 32'(acc_c[1]), 32'd4);
    end
    if (rsp_cnt >= 2) begin
      check("b2b_rsp0_cycle", 32'(rsp_c[0]), 32'd3);
      check("b2b_rsp0_data", rsp_d[0], 32'hDEADBEEF);
      check("b2b_rsp1_cycle", 32'(rsp_c[1]), 32'd7);
      check("b2b_rsp1_data", rsp_d[1], 32'hCA000000);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
